mjpg_word_packer: RTL and testbench

- Packs the MJPG encoder's byte stream (jvalid/jpeg) into WORD_BYTES-wide words for a DMA or memory writer.
- Detects the JPEG EOI marker (0xFF 0xD9) and closes each frame with a partial, byte-masked last word.
- Buffers words in a FIFO_DEPTH-entry FIFO with valid/ready output.
- Reports per-frame byte counts and a sticky overflow flag, because the encoder cannot be back-pressured.

---
 rtl/mjpg_word_packer.sv | 97 +++++++++
 tb/tb_mjpg_word_packer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mjpg_word_packer.sv
// mjpg_word_packer: packs JPEG bytes into byte-masked words, closes frames on EOI, buffers them in a FWFT FIFO
//   clk, rst (sync, active-low) | in_valid, in_data, flush: encoder byte stream and partial-word flush
//   out_valid, out_ready, out_data, out_keep, out_last: word stream | frame_bytes, frame_done, overflow: status
module mjpg_word_packer #(
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic [WORD_BYTES-1:0]   out_keep,
  output logic                    out_last,
  output logic [CNT_W-1:0]        frame_bytes,
  output logic                    frame_done,
  output logic                    overflow
);
  localparam int W  = 8*WORD_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [W-1:0]          buf_data, nxt_data;
  logic [WORD_BYTES-1:0] buf_keep, nxt_keep;
  logic [3:0]            idx, lane;
  logic                  prev_ff, eoi, close, empty, full, push, pop;
  logic [CNT_W-1:0]      cnt, cnt_inc;
  logic [W-1:0]          mem_data [FIFO_DEPTH];
  logic [WORD_BYTES-1:0] mem_keep [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [AW:0]           wptr, rptr;
  assign lane = BIG_ENDIAN != 0 ? 4'(WORD_BYTES-1) - idx : idx;
  always_comb begin
    nxt_data = buf_data;
    nxt_keep = buf_keep;
    for (int i = 0; i < WORD_BYTES; i++)
      if (in_valid && lane == 4'(i)) begin
        nxt_data[8*i +: 8] = in_data;
        nxt_keep[i] = 1'b1;
      end
  end
  assign eoi     = in_valid && prev_ff && in_data == 8'hD9;
  // flush closes only if a byte is buffered once this cycle's byte is included
  assign close   = (in_valid && idx == 4'(WORD_BYTES-1)) || eoi || (flush && (in_valid || idx != 4'd0));
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign empty   = wptr == rptr;
  assign full    = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign pop     = !empty && out_ready;
  // a pop on the same edge frees the slot, so a full FIFO still accepts the word
  assign push    = close && (!full || pop);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_data[rptr[AW-1:0]];
  assign out_keep  = empty ? '0 : mem_keep[rptr[AW-1:0]];
  assign out_last  = !empty && mem_last[rptr[AW-1:0]];
  always_ff @(posedge clk)
    if (push) begin
      mem_data[wptr[AW-1:0]] <= nxt_data;
      mem_keep[wptr[AW-1:0]] <= nxt_keep;
      mem_last[wptr[AW-1:0]] <= eoi;
    end
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_data    <= '0;
      buf_keep    <= '0;
      idx         <= '0;
      prev_ff     <= 1'b0;
      cnt         <= '0;
      frame_bytes <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      if (in_valid) prev_ff <= in_data == 8'hFF;
      if (close) begin
        buf_data <= '0;
        buf_keep <= '0;
        idx      <= '0;
      end else if (in_valid) begin
        buf_data <= nxt_data;
        buf_keep <= nxt_keep;
        idx      <= idx + 1'b1;
      end
      frame_done <= eoi;
      if (eoi) begin
        frame_bytes <= cnt_inc;
        cnt         <= '0;
      end else if (in_valid) cnt <= cnt_inc;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (close && !push) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mjpg_word_packer.sv
// tb_mjpg_word_packer: checks two packer configurations against a list-based reference model
module tb_mjpg_word_packer;
  logic clk = 0, rst = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic ov [2], ol [2], fdn [2], ovf [2];
  logic [31:0] od [2];
  logic [3:0] ok [2];
  logic [23:0] fb0;
  logic [5:0] fb1;
  int n_chk = 0, n_fail = 0;
  logic [7:0] cur [2][8];
  logic [31:0] wd [2][16];
  logic [3:0] wk [2][16];
  logic wl [2][16];
  int mn [2], mhd [2], msz [2];
  int unsigned mcnt [2], mfb [2];
  logic mpff [2], mdone [2], movf [2];
  always #5 clk = ~clk;
  mjpg_word_packer u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_keep(ok[0]), .out_last(ol[0]),
    .frame_bytes(fb0), .frame_done(fdn[0]), .overflow(ovf[0]));
  mjpg_word_packer #(.WORD_BYTES(4), .BIG_ENDIAN(0), .FIFO_DEPTH(2), .CNT_W(6)) u1 (.clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_keep(ok[1]), .out_last(ol[1]), .frame_bytes(fb1), .frame_done(fdn[1]),
    .overflow(ovf[1]));
  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d]: got %0h expected %0h", nm, k, act, exp);
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int be = k == 0 ? 1 : 0;
      int fd = k == 0 ? 16 : 2;
      int unsigned cmax = k == 0 ? 32'hFFFFFF : 32'd63;
      int lane, slot;
      bit eoi, pop;
      logic [31:0] d;
      logic [3:0] kp;
      if (!rst) begin
        mn[k] = 0; mhd[k] = 0; msz[k] = 0; mpff[k] = 0;
        mcnt[k] = 0; mfb[k] = 0; mdone[k] = 0; movf[k] = 0;
      end else begin
        pop = msz[k] > 0 && out_ready;
        eoi = 0;
        if (in_valid) begin
          cur[k][mn[k]] = in_data;
          mn[k]++;
          eoi = mpff[k] && in_data == 8'hD9;
          mpff[k] = in_data == 8'hFF;
        end
        mdone[k] = eoi;
        if (eoi) begin
          mfb[k] = mcnt[k] + 1 > cmax ? cmax : mcnt[k] + 1;
          mcnt[k] = 0;
        end else if (in_valid && mcnt[k] < cmax) mcnt[k]++;
        if (pop) begin
          mhd[k] = (mhd[k] + 1) % 16;
          msz[k]--;
        end
        if (mn[k] == 4 || eoi || (flush && mn[k] > 0)) begin
          d = 0;
          kp = 0;
          for (int j = 0; j < mn[k]; j++) begin
            lane = be ? 3 - j : j;
            d[lane*8 +: 8] = cur[k][j];
            kp[lane] = 1;
          end
          if (msz[k] < fd) begin
            slot = (mhd[k] + msz[k]) % 16;
            wd[k][slot] = d;
            wk[k][slot] = kp;
            wl[k][slot] = eoi;
            msz[k]++;
          end else movf[k] = 1;
          mn[k] = 0;
        end
      end
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit v = msz[k] > 0;
      int h = mhd[k];
      chk("out_valid", k, 32'(ov[k]), 32'(v));
      chk("out_data", k, od[k], v ? wd[k][h] : 32'd0);
      chk("out_keep", k, 32'(ok[k]), v ? 32'(wk[k][h]) : 32'd0);
      chk("out_last", k, 32'(ol[k]), v ? 32'(wl[k][h]) : 32'd0);
      chk("frame_bytes", k, k == 0 ? 32'(fb0) : 32'(fb1), mfb[k]);
      chk("frame_done", k, 32'(fdn[k]), 32'(mdone[k]));
      chk("overflow", k, 32'(ovf[k]), 32'(movf[k]));
    end
  endtask
  task automatic cyc(bit v, logic [7:0] d, bit f);
    in_valid = v;
    in_data = d;
    flush = f;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    rst = 0;
    cyc(0, 0, 0);
    rst = 1;
  endtask
  initial begin
    int n;
    logic [7:0] s2 [7];
    s2 = '{8'hFF, 8'hD8, 8'h11, 8'h22, 8'h33, 8'hFF, 8'hD9};
    @(negedge clk);
    cyc(0, 0, 0);
    do_reset();
    chk("reset_valid", 0, 32'(ov[0]), 0);
    chk("reset_fb", 0, 32'(fb0), 0);
    out_ready = 1;
    cyc(1, 8'hFF, 0); cyc(1, 8'hD8, 0); cyc(1, 8'h01, 0); cyc(1, 8'h02, 0);
    chk("t1_data", 0, od[0], 32'hFFD80102);
    chk("t1_keep", 0, 32'(ok[0]), 32'hF);
    chk("t1_last", 0, 32'(ol[0]), 0);
    chk("t1_data", 1, od[1], 32'h0201D8FF);
    do_reset();
    foreach (s2[i]) cyc(1, s2[i], 0);
    chk("t2_data", 0, od[0], 32'h33FFD900);
    chk("t2_keep", 0, 32'(ok[0]), 32'hE);
    chk("t2_last", 0, 32'(ol[0]), 1);
    chk("t2_done", 0, 32'(fdn[0]), 1);
    chk("t2_fb", 0, 32'(fb0), 7);
    chk("t2_data", 1, od[1], 32'h00D9FF33);
    cyc(0, 0, 0);
    chk("t2_done_off", 0, 32'(fdn[0]), 0);
    cyc(1, 8'hAA, 0); cyc(1, 8'hBB, 0); cyc(0, 0, 1);
    chk("t3_data", 1, od[1], 32'h0000BBAA);
    chk("t3_keep", 1, 32'(ok[1]), 32'h3);
    chk("t3_data", 0, od[0], 32'hAABB0000);
    chk("t3_fb", 0, 32'(fb0), 7);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("t3_empty_flush", 0, 32'(ov[0]), 0);
    cyc(1, 8'hFF, 0); cyc(1, 8'h00, 0); cyc(1, 8'hD9, 1);
    chk("t3_stuff_last", 1, 32'(ol[1]), 0);
    chk("t3_stuff_data", 1, od[1], 32'h00D900FF);
    chk("t3_stuff_done", 0, 32'(fdn[0]), 0);
    do_reset();
    out_ready = 0;
    for (int i = 1; i <= 12; i++) cyc(1, 8'(i), 0);
    chk("t4_ovf", 1, 32'(ovf[1]), 1);
    chk("t4_ovf", 0, 32'(ovf[0]), 0);
    chk("t4_head", 1, od[1], 32'h04030201);
    out_ready = 1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (ov[1]) n++;
      cyc(0, 0, 0);
    end
    chk("t4_drained", 1, 32'(n), 2);
    chk("t4_ovf_sticky", 1, 32'(ovf[1]), 1);
    do_reset();
    out_ready = 0;
    for (int i = 1; i <= 11; i++) cyc(1, 8'(i), 0);
    out_ready = 1;
    cyc(1, 8'd12, 0);
    chk("t5_ovf", 1, 32'(ovf[1]), 0);
    chk("t5_head", 1, od[1], 32'h08070605);
    cyc(0, 0, 0);
    chk("t5_next", 1, od[1], 32'h0C0B0A09);
    cyc(0, 0, 0);
    cyc(1, 8'h21, 0); cyc(1, 8'h22, 0); cyc(1, 8'h23, 0);
    do_reset();
    chk("t6_valid", 0, 32'(ov[0]), 0);
    chk("t6_data", 0, od[0], 0);
    chk("t6_done", 0, 32'(fdn[0]), 0);
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0); cyc(1, 8'h44, 0);
    chk("t6_word", 0, od[0], 32'h11223344);
    chk("t6_keep", 0, 32'(ok[0]), 32'hF);
    do_reset();
    for (int i = 0; i < 70; i++) cyc(1, 8'h55, 0);
    cyc(1, 8'hFF, 0); cyc(1, 8'hD9, 0);
    chk("sat_fb", 1, 32'(fb1), 63);
    chk("sat_fb", 0, 32'(fb0), 72);
    for (int i = 0; i < 4000; i++) begin
      int r = $urandom_range(0, 7);
      logic [7:0] b = r < 2 ? 8'hFF : r == 2 ? 8'hD9 : r == 3 ? 8'h00 : 8'($urandom);
      out_ready = i < 2000 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 9) != 0;
      rst = $urandom_range(0, 499) != 0;
      cyc($urandom_range(0, 9) < 7, b, $urandom_range(0, 19) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
